// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared constants and loader state type for the instruction
//                memory loader. IMEM_BASE is the byte address of word 0 and
//                IMEM_WORDS the capacity in 32-bit words.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam logic [31:0] IMEM_BASE  = 32'hBFC00000;
    localparam int          IMEM_WORDS = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_word_packer
//  Description : Shifts accepted bytes into a 32-bit word, little-endian
//                (first byte lands in bits [7:0]). Flags the byte that
//                completes a word.
//  Ports       : clk, rst_n   - clock, async active-low reset
//                clear        - drop any partial word (new load)
//                byte_en      - a byte is accepted this cycle
//                byte_data    - the accepted byte
//                word         - assembled word (held until next byte)
//                word_last    - byte_en on the 4th byte of a word
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_last
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    // Shifting right means after four bytes the first one sits in the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (clear) begin
            r_cnt  <= 2'd0;
        end else if (byte_en) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= {byte_data, r_word[31:8]};
        end
    end

    assign word      = r_word;
    assign word_last = byte_en && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Loads len_words 32-bit words from a byte stream into
//                instruction memory starting at BASE_ADDR, holding the CPU
//                out of fetch until a load completes cleanly.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                start, len_words     - load request and word count
//                in_valid/in_data/in_ready - byte stream handshake
//                wr_en/wr_addr/wr_data - one-cycle memory word write
//                busy, done, err      - load status
//                cpu_hold             - low only after a successful load
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = IMEM_BASE,
    parameter int          MAX_WORDS = IMEM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] len_words,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    localparam logic [31:0] c_max_words = 32'(MAX_WORDS);

    loader_state_t r_state;
    loader_state_t w_state_nxt;

    logic [31:0] r_addr;
    logic [10:0] r_len;
    logic [10:0] r_wcnt;
    logic        r_err;

    logic w_start_win;
    logic w_len_zero;
    logic w_len_over;
    logic w_load_go;
    logic w_byte_acc;
    logic w_word_last;
    logic w_more;

    // start only counts while idle or finished; mid-load pulses are dropped.
    assign w_start_win = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_len_zero  = (len_words == 11'd0);
    assign w_len_over  = ({21'd0, len_words} > c_max_words);
    assign w_load_go   = w_start_win && !w_len_zero && !w_len_over;
    assign w_byte_acc  = in_valid && (r_state == COLLECT);
    // r_wcnt counts words already written, so +1 includes the one in WRITE.
    assign w_more      = ((r_wcnt + 11'd1) < r_len);

    imem_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_load_go),
        .byte_en   (w_byte_acc),
        .byte_data (in_data),
        .word      (wr_data),
        .word_last (w_word_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        wr_en       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cpu_hold    = 1'b1;
        case (r_state)
            IDLE, DONE: begin
                if (r_state == DONE && !r_err) begin
                    done     = 1'b1;
                    cpu_hold = 1'b0;
                end
                if (w_start_win) begin
                    w_state_nxt = w_load_go ? COLLECT : DONE;
                end
            end
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_word_last) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_en       = 1'b1;
                busy        = 1'b1;
                w_state_nxt = w_more ? COLLECT : DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= BASE_ADDR;
            r_len  <= 11'd0;
            r_wcnt <= 11'd0;
            r_err  <= 1'b0;
        end else if (w_start_win) begin
            r_err <= w_len_over;
            if (w_load_go) begin
                r_addr <= BASE_ADDR;
                r_len  <= len_words;
                r_wcnt <= 11'd0;
            end
        end else if (r_state == WRITE) begin
            r_addr <= r_addr + 32'd4;
            r_wcnt <= r_wcnt + 11'd1;
        end
    end

    assign wr_addr = r_addr;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] len_words = 11'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len_words (len_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_hold  (cpu_hold)
    );

    // Record every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [10:0] len);
        start     = 1'b1;
        len_words = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("byte_timeout", {31'd0, in_ready}, 32'd1);
        tick();
    endtask

    task automatic send_word(input logic [31:0] w, input logic bp);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (bp) begin
                in_valid = 1'b0;
                tick();
            end
        end
    endtask

    task automatic wait_not_busy(input int max);
        int n = 0;
        @(negedge clk);
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check("load_finish_busy", {31'd0, busy}, 32'd0);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wr_en",    {31'd0, wr_en},    32'd0);
        check("rst_wr_addr",  wr_addr,           32'hBFC00000);
        check("rst_wr_data",  wr_data,           32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        check("rst_err",      {31'd0, err},      32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Two-word load, no gaps
        wq_addr.delete(); wq_data.delete();
        do_start(11'd2);
        check("a_busy", {31'd0, busy}, 32'd1);
        check("a_in_ready", {31'd0, in_ready}, 32'd1);
        send_word(32'h00000013, 1'b0);
        send_word(32'h00100093, 1'b0);
        in_valid = 1'b0;
        wait_not_busy(20);
        check("a_nwrites", wq_addr.size(), 32'd2);
        if (wq_addr.size() == 2) begin
            check("a_addr0", wq_addr[0], 32'hBFC00000);
            check("a_data0", wq_data[0], 32'h00000013);
            check("a_addr1", wq_addr[1], 32'hBFC00004);
            check("a_data1", wq_data[1], 32'h00100093);
        end
        check("a_done",     {31'd0, done},     32'd1);
        check("a_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("a_in_ready_after", {31'd0, in_ready}, 32'd0);

        // Same stream with a gap after every byte, restarted from DONE
        wq_addr.delete(); wq_data.delete();
        do_start(11'd2);
        check("b_done_cleared", {31'd0, done}, 32'd0);
        check("b_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        send_word(32'h00000013, 1'b1);
        send_word(32'h00100093, 1'b1);
        wait_not_busy(20);
        check("b_nwrites", wq_addr.size(), 32'd2);
        if (wq_addr.size() == 2) begin
            check("b_addr0", wq_addr[0], 32'hBFC00000);
            check("b_data0", wq_data[0], 32'h00000013);
            check("b_addr1", wq_addr[1], 32'hBFC00004);
            check("b_data1", wq_data[1], 32'h00100093);
        end
        check("b_done", {31'd0, done}, 32'd1);

        // Length bounds
        wq_addr.delete(); wq_data.delete();
        do_start(11'd0);
        tick();
        check("z_done",     {31'd0, done},     32'd1);
        check("z_err",      {31'd0, err},      32'd0);
        check("z_busy",     {31'd0, busy},     32'd0);
        check("z_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        do_start(11'd1025);
        tick();
        check("o_err",      {31'd0, err},      32'd1);
        check("o_done",     {31'd0, done},     32'd0);
        check("o_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("o_in_ready", {31'd0, in_ready}, 32'd0);
        check("zo_nwrites", wq_addr.size(), 32'd0);
        do_start(11'd0);
        check("z2_err_cleared", {31'd0, err}, 32'd0);

        // Full memory
        wq_addr.delete(); wq_data.delete();
        do_start(11'd1024);
        check("f_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 1024; i++) begin
            logic [15:0] v;
            v = i[15:0];
            send_word({8'h5A, 8'hA5, v[15:8], v[7:0]}, 1'b0);
        end
        in_valid = 1'b0;
        wait_not_busy(20);
        check("f_nwrites", wq_addr.size(), 32'd1024);
        for (int i = 0; i < wq_addr.size(); i++) begin
            logic [15:0] v;
            v = i[15:0];
            check($sformatf("f_addr%0d", i), wq_addr[i], 32'hBFC00000 + 32'(i) * 32'd4);
            check($sformatf("f_data%0d", i), wq_data[i], {8'h5A, 8'hA5, v[15:8], v[7:0]});
        end
        if (wq_addr.size() == 1024) check("f_last_addr", wq_addr[1023], 32'hBFC00FFC);
        check("f_done",     {31'd0, done},     32'd1);
        check("f_err",      {31'd0, err},      32'd0);
        check("f_in_ready", {31'd0, in_ready}, 32'd0);

        // Reset after 6 bytes of a 4-word load
        wq_addr.delete(); wq_data.delete();
        do_start(11'd4);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("r_in_ready", {31'd0, in_ready}, 32'd0);
        check("r_wr_en",    {31'd0, wr_en},    32'd0);
        check("r_wr_addr",  wr_addr,           32'hBFC00000);
        check("r_wr_data",  wr_data,           32'd0);
        check("r_busy",     {31'd0, busy},     32'd0);
        check("r_done",     {31'd0, done},     32'd0);
        check("r_err",      {31'd0, err},      32'd0);
        check("r_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        tick();
        tick();
        check("r_nwrites", wq_addr.size(), 32'd1);
        if (wq_addr.size() == 1) begin
            check("r_addr0", wq_addr[0], 32'hBFC00000);
            check("r_data0", wq_data[0], 32'h44332211);
        end
        rst_n = 1'b1;
        wq_addr.delete(); wq_data.delete();
        do_start(11'd1);
        check("r2_busy_first_edge", {31'd0, busy}, 32'd1);
        send_word(32'hCAFEF00D, 1'b0);
        in_valid = 1'b0;
        wait_not_busy(20);
        check("r2_nwrites", wq_addr.size(), 32'd1);
        if (wq_addr.size() == 1) begin
            check("r2_addr0", wq_addr[0], 32'hBFC00000);
            check("r2_data0", wq_data[0], 32'hCAFEF00D);
        end
        check("r2_done", {31'd0, done}, 32'd1);

        // start during COLLECT is ignored
        wq_addr.delete(); wq_data.delete();
        do_start(11'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        in_valid = 1'b0;
        do_start(11'd5);
        send_byte(8'h03);
        send_byte(8'h04);
        send_word(32'h89ABCDEF, 1'b0);
        in_valid = 1'b0;
        wait_not_busy(20);
        tick();
        check("s_nwrites", wq_addr.size(), 32'd2);
        if (wq_addr.size() == 2) begin
            check("s_data0", wq_data[0], 32'h04030201);
            check("s_addr1", wq_addr[1], 32'hBFC00004);
            check("s_data1", wq_data[1], 32'h89ABCDEF);
        end
        check("s_done", {31'd0, done}, 32'd1);
        check("s_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hBFC00000, meaning byte address of instruction-memory word 0.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, meaning instruction-memory capacity in 32-bit words (4 KiB).
REQ-003 SHALL have ports, one per line, clock and reset first:
 clk  in  1  single clock; all state on rising edge
 rst_n  in  1  asynchronous, active-low reset
 start  in  1  single-cycle pulse requesting a load
 len_words  in  11  number of words to load, sampled on accepted start
 in_valid  in  1  byte-stream valid
 in_data  in  8  byte-stream data
 in_ready  out  1  byte-stream ready; transfer when in_valid & in_ready
 wr_en  out  1  one-cycle word write strobe to instruction memory
 wr_addr  out  32  byte address of word being written
 wr_data  out  32  little-endian assembled word
 busy  out  1  load in progress
 done  out  1  last load completed successfully
 err  out  1  last start rejected (len_words > MAX_WORDS)
 cpu_hold  out  1  holds core out of fetch while memory is not valid

Function
REQ-004 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE.
REQ-005 IDLE: start=1 and len_words in 1..MAX_WORDS -> COLLECT next cycle; word count and byte count cleared, address = BASE_ADDR, err cleared.
REQ-006 IDLE or DONE: start=1 and len_words=0 -> DONE next cycle, no writes, err=0.
REQ-007 IDLE or DONE: start=1 and len_words > MAX_WORDS -> DONE next cycle, no writes, err=1, done=0.
REQ-008 start in DONE with valid length SHALL restart exactly as from IDLE; start in COLLECT or WRITE SHALL be ignored.
REQ-009 in_ready SHALL be 1 only in COLLECT; bytes presented in any other state SHALL not be consumed.
REQ-010 Byte order: k-th accepted byte of a word (k=0..3) SHALL occupy wr_data[8k+7:8k] (first byte = LSB).
REQ-011 Acceptance of the 4th byte SHALL move COLLECT -> WRITE; in WRITE, wr_en=1 for exactly one cycle with the complete word.
REQ-012 wr_addr SHALL equal BASE_ADDR + 4*word_index; it advances by 4 after each write; arithmetic is 32-bit, no wrap within MAX_WORDS.
REQ-013 WRITE -> COLLECT when words written < len_words, else WRITE -> DONE.
REQ-014 Throughput: at most one word per 5 cycles (4 byte cycles + 1 write cycle); in_valid gaps stall COLLECT without losing the partial word.
REQ-015 busy=1 in COLLECT and WRITE only; done=1 in DONE when err=0; done clears when a new load starts.
REQ-016 cpu_hold SHALL be 1 in every state except DONE with err=0.
REQ-017 wr_data and wr_addr SHALL be stable whenever wr_en=1; their values when wr_en=0 are don't-care.

Reset
REQ-018 rst_n=0 SHALL asynchronously force IDLE, in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, done=0, err=0, cpu_hold=1.
REQ-019 Reset mid-load SHALL discard any partial word and issue no further writes; memory contents already written are not retracted.
REQ-020 Deassertion of rst_n SHALL need no start-up cycles; start is honoured on the first clock edge after deassertion.

Structure
REQ-021 Shared package imem_pkg SHALL hold IMEM_BASE (32'hBFC00000), IMEM_WORDS (1024), and the loader state enum type.
REQ-022 One sub-module imem_word_packer (byte shift-in, 2-bit byte counter, word-complete flag) is natural; FSM and address counter stay in imem_loader.

Verification
REQ-023 Load 2 words: start, len_words=2, bytes 13,00,00,00,93,00,10,00 -> writes 32'h00000013 @ BFC00000, 32'h00100093 @ BFC00004; done=1, cpu_hold=0.
REQ-024 Backpressure: same stream with in_valid low on alternate cycles -> identical writes, no byte lost or duplicated, wr_en pulses exactly twice.
REQ-025 Length bounds: len_words=0 -> done=1, no wr_en; len_words=1025 -> err=1, done=0, cpu_hold=1, no wr_en.
REQ-026 Full memory: len_words=1024 -> last write @ BFC00FFC, then DONE; in_ready=0 afterwards.
REQ-027 Reset mid-load: rst_n low after 6 bytes of a 4-word load -> exactly 1 write issued, all outputs at reset values, next start loads from BFC00000.
REQ-028 start pulsed during COLLECT -> ignored; load completes with original len_words.
